// File: rtl/det2_ctrl_pkg.sv
// Shared types and constants for the 2x2 determinant controller.
package det2_ctrl_pkg;

    localparam int WIDTH_DEF = 32;
    localparam logic [31:0] ZERO = 32'h0000_0000;

    // IEEE-754 single-precision field bounds
    localparam int SIGN_BIT = 31;
    localparam int MAG_MSB  = 30;
    localparam int MAG_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE,
        MUL_AD,
        MUL_BC,
        SUB,
        DONE
    } state_t;

    // True for +0 and -0: the sign bit is ignored.
    function automatic logic fp_is_zero(input logic [31:0] v);
        return (v[MAG_MSB:MAG_LSB] == '0) && (v[SIGN_BIT] == v[SIGN_BIT]);
    endfunction

endpackage

// File: rtl/det2_ctrl_op_timer.sv
// Per-operation watchdog: restarts on every start pulse, flags expiry once
// TIMEOUT cycles (start cycle included) have passed without a clear.
module op_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;
    logic          run;

    // Count cycles since the last start; count is 1 in the cycle after start.
    always_ff @(posedge clk) begin
        if (rst) begin
            run   <= 1'b0;
            count <= '0;
        end else if (start) begin
            run   <= 1'b1;
            count <= CW'(1);
        end else if (clear) begin
            run   <= 1'b0;
        end else if (run && !expired) begin
            count <= count + 1'b1;
        end
    end

    // Gated by start so a stale count from the previous op never fires on entry.
    assign expired = run && !start && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/det2_ctrl.sv
// 2x2 determinant controller: sequences a*d, b*c and ad-bc through shared
// multiplier/adder units, with a per-operation timeout.
module det2_ctrl
    import det2_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_x,
    output logic [WIDTH-1:0] mul_y,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_result,
    output logic             add_start,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    output logic             add_sub,
    input  logic             add_done,
    input  logic [WIDTH-1:0] add_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] det,
    output logic             singular,
    output logic             error
);

    state_t state, next_state;
    logic   entry;          // first cycle in the current state
    logic   mul_ack, add_ack, timeout, expired;

    logic [WIDTH-1:0] a_r, b_r, c_r, d_r, ad_r, bc_r, det_r;
    logic             singular_r, error_r;

    op_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start | add_start),
        .clear   (next_state != state),
        .expired (expired)
    );

    // State register plus first-cycle marker used to pulse the unit starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            entry <= 1'b0;
        end else begin
            state <= next_state;
            entry <= (next_state != state);
        end
    end

    // Next-state and unit-interface decode; a done in the start cycle or in a
    // state not waiting for it is a stray and is dropped.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mul_start  = 1'b0;
        mul_x      = '0;
        mul_y      = '0;
        add_start  = 1'b0;
        add_x      = '0;
        add_y      = '0;
        add_sub    = 1'b0;
        mul_ack    = 1'b0;
        add_ack    = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = MUL_AD;
            end
            MUL_AD: begin
                mul_start = entry;
                mul_x     = a_r;
                mul_y     = d_r;
                mul_ack   = mul_done && !entry;
                timeout   = expired && !mul_ack;
                if (mul_ack)      next_state = MUL_BC;
                else if (timeout) next_state = DONE;
            end
            MUL_BC: begin
                mul_start = entry;
                mul_x     = b_r;
                mul_y     = c_r;
                mul_ack   = mul_done && !entry;
                timeout   = expired && !mul_ack;
                if (mul_ack)      next_state = SUB;
                else if (timeout) next_state = DONE;
            end
            SUB: begin
                add_start = entry;
                add_x     = ad_r;
                add_y     = bc_r;
                add_sub   = 1'b1;
                add_ack   = add_done && !entry;
                timeout   = expired && !add_ack;
                if (add_ack || timeout) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, partial products and the result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= '0;
            b_r        <= '0;
            c_r        <= '0;
            d_r        <= '0;
            ad_r       <= '0;
            bc_r       <= '0;
            det_r      <= '0;
            singular_r <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_r     <= a;
                b_r     <= b;
                c_r     <= c;
                d_r     <= d;
                error_r <= 1'b0;
            end
            if (state == MUL_AD && mul_ack) ad_r <= mul_result;
            if (state == MUL_BC && mul_ack) bc_r <= mul_result;
            if (add_ack) begin
                det_r      <= add_result;
                singular_r <= fp_is_zero(32'(add_result));
            end
            if (timeout) begin
                det_r      <= WIDTH'(ZERO);
                singular_r <= 1'b1;
                error_r    <= 1'b1;
            end
        end
    end

    assign det      = det_r;
    assign singular = singular_r;
    assign error    = error_r;

endmodule

// File: tb/tb_det2_ctrl.sv
// Directed bench for det2_ctrl with behavioural FP multiplier/adder models.
module tb_det2_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, singular, error;
    logic [31:0] a = '0, b = '0, c = '0, d = '0, det;
    logic        mul_start, add_start, add_sub;
    logic [31:0] mul_x, mul_y, add_x, add_y;
    logic [31:0] mul_result = '0, add_result = '0;
    logic        mul_done, add_done;
    logic        mdone_m = 1'b0, adone_m = 1'b0, inj_mdone = 1'b0;

    int checks = 0, fails = 0;
    int mlat = 1, alat = 1;
    logic add_en = 1'b1;

    assign mul_done = mdone_m | inj_mdone;
    assign add_done = adone_m;

    always #5 clk = ~clk;

    det2_ctrl #(.WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
        .mul_done(mul_done), .mul_result(mul_result),
        .add_start(add_start), .add_x(add_x), .add_y(add_y), .add_sub(add_sub),
        .add_done(add_done), .add_result(add_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .det(det), .singular(singular), .error(error)
    );

    function automatic real sp2r(input logic [31:0] v);
        real m;
        int  e;
        if (v[30:0] == 31'd0) return 0.0;
        e = int'(v[30:23]) - 127;
        m = 1.0 + real'(v[22:0]) / 8388608.0;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return v[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2sp(input real x);
        logic        s;
        int          e;
        real         m;
        logic [22:0] f;
        logic [7:0]  eb;
        if (x == 0.0) return 32'h0;
        s = (x < 0.0);
        m = s ? -x : x;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f  = 23'($rtoi((m - 1.0) * 8388608.0));
        eb = 8'(e);
        return {s, eb, f};
    endfunction

    // Multiplier model: done arrives mlat cycles after the start cycle.
    int          mcnt = 0;
    logic [31:0] mq = '0;
    always @(posedge clk) begin
        mdone_m <= 1'b0;
        if (mul_start) begin
            if (mlat <= 1) begin
                mdone_m    <= 1'b1;
                mul_result <= r2sp(sp2r(mul_x) * sp2r(mul_y));
                mcnt       <= 0;
            end else begin
                mq   <= r2sp(sp2r(mul_x) * sp2r(mul_y));
                mcnt <= mlat - 1;
            end
        end else if (mcnt == 1) begin
            mdone_m    <= 1'b1;
            mul_result <= mq;
            mcnt       <= 0;
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end
    end

    // Adder model: same timing, can be muted to provoke a timeout.
    int          acnt = 0;
    logic [31:0] aq = '0;
    always @(posedge clk) begin
        adone_m <= 1'b0;
        if (add_start) begin
            aq <= r2sp(add_sub ? sp2r(add_x) - sp2r(add_y) : sp2r(add_x) + sp2r(add_y));
            if (alat <= 1) begin
                adone_m    <= add_en;
                add_result <= r2sp(add_sub ? sp2r(add_x) - sp2r(add_y)
                                           : sp2r(add_x) + sp2r(add_y));
                acnt       <= 0;
            end else begin
                acnt <= alat - 1;
            end
        end else if (acnt == 1) begin
            adone_m    <= add_en;
            add_result <= aq;
            acnt       <= 0;
        end else if (acnt > 1) begin
            acnt <= acnt - 1;
        end
    end

    // Event counters, accept/result logs and start-protocol monitor.
    int          cyc = 0, n_mul = 0, n_add = 0, viol = 0;
    logic        mpend = 1'b0, apend = 1'b0;
    int          acc_q[$];
    logic [31:0] acc_a[$];
    logic [31:0] res_q[$];
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        n_mul <= n_mul + int'(mul_start);
        n_add <= n_add + int'(add_start);
        if (in_valid && in_ready && !rst) begin
            acc_q.push_back(cyc);
            acc_a.push_back(a);
        end
        if (out_valid && out_ready && !rst) res_q.push_back(det);
        if (rst || out_valid) begin
            mpend <= 1'b0;
            apend <= 1'b0;
        end else begin
            viol  <= viol + int'(mul_start && add_start) + int'(mul_start && mpend)
                          + int'(add_start && apend);
            mpend <= mul_start ? 1'b1 : (mul_done ? 1'b0 : mpend);
            apend <= add_start ? 1'b1 : (add_done ? 1'b0 : apend);
        end
    end

    task automatic send(input logic [31:0] va, vb, vc, vd);
        @(negedge clk);
        a = va; b = vb; c = vc; d = vd;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; c = 32'h7F80_0000; d = 32'hFFFF_FFFF;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_out;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (mul_start !== 1'b0) begin fails++; $display("FAIL rst_mul_start: got %b want 0", mul_start); end
        checks++; if (add_start !== 1'b0) begin fails++; $display("FAIL rst_add_start: got %b want 0", add_start); end
        checks++; if (add_sub !== 1'b0) begin fails++; $display("FAIL rst_add_sub: got %b want 0", add_sub); end
        checks++; if (error !== 1'b0) begin fails++; $display("FAIL rst_error: got %b want 0", error); end
        checks++; if (singular !== 1'b0) begin fails++; $display("FAIL rst_singular: got %b want 0", singular); end
        checks++; if (det !== 32'h0) begin fails++; $display("FAIL rst_det: got %h want 0", det); end
        checks++; if ({mul_x, mul_y} !== 64'h0) begin fails++; $display("FAIL rst_mul_xy: got %h %h want 0", mul_x, mul_y); end
        checks++; if ({add_x, add_y} !== 64'h0) begin fails++; $display("FAIL rst_add_xy: got %h %h want 0", add_x, add_y); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        int n, m0, a0;
        m0 = n_mul; a0 = n_add;
        send(32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4080_0000);
        wait_out(n);
        checks++; if (n !== 6) begin fails++; $display("FAIL basic_latency: got %0d want 6", n); end
        checks++; if (det !== 32'h4120_0000) begin fails++; $display("FAIL basic_det: got %h want 41200000", det); end
        checks++; if (singular !== 1'b0) begin fails++; $display("FAIL basic_singular: got %b want 0", singular); end
        checks++; if (error !== 1'b0) begin fails++; $display("FAIL basic_error: got %b want 0", error); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_in_ready: got %b want 0", in_ready); end
        checks++; if (n_mul - m0 !== 2) begin fails++; $display("FAIL basic_mul_starts: got %0d want 2", n_mul - m0); end
        checks++; if (n_add - a0 !== 1) begin fails++; $display("FAIL basic_add_starts: got %0d want 1", n_add - a0); end
        release_out();
    endtask

    task automatic test_singular;
        int n;
        send(32'h4000_0000, 32'h4080_0000, 32'h3F80_0000, 32'h4000_0000);
        wait_out(n);
        checks++; if (n !== 6) begin fails++; $display("FAIL sing_latency: got %0d want 6", n); end
        checks++; if (det !== 32'h0) begin fails++; $display("FAIL sing_det: got %h want 00000000", det); end
        checks++; if (singular !== 1'b1) begin fails++; $display("FAIL sing_flag: got %b want 1", singular); end
        checks++; if (error !== 1'b0) begin fails++; $display("FAIL sing_error: got %b want 0", error); end
        release_out();
    endtask

    task automatic test_slow_units;
        int n, m0, a0;
        mlat = 5; alat = 5;
        m0 = n_mul; a0 = n_add;
        send(32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 32'h4080_0000);
        wait_out(n);
        checks++; if (n !== 18) begin fails++; $display("FAIL slow_latency: got %0d want 18", n); end
        checks++; if (det !== 32'h40A0_0000) begin fails++; $display("FAIL slow_det: got %h want 40a00000", det); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (det !== 32'h40A0_0000) begin fails++; $display("FAIL slow_hold_det[%0d]: got %h want 40a00000", i, det); end
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL slow_hold_in_ready[%0d]: got %b want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL slow_hold_out_valid[%0d]: got %b want 1", i, out_valid); end
        end
        checks++; if (n_mul - m0 !== 2) begin fails++; $display("FAIL slow_mul_starts: got %0d want 2", n_mul - m0); end
        checks++; if (n_add - a0 !== 1) begin fails++; $display("FAIL slow_add_starts: got %0d want 1", n_add - a0); end
        release_out();
        mlat = 1; alat = 1;
    endtask

    task automatic test_timeout;
        int n, k;
        add_en = 1'b0;
        send(32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4080_0000);
        n = 0;
        while (!add_start && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (add_start !== 1'b1) begin fails++; $display("FAIL tmo_add_start_seen: got %b want 1", add_start); end
        k = 0;
        while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
        checks++; if (k !== 8) begin fails++; $display("FAIL tmo_cycles: got %0d want 8", k); end
        checks++; if (error !== 1'b1) begin fails++; $display("FAIL tmo_error: got %b want 1", error); end
        checks++; if (singular !== 1'b1) begin fails++; $display("FAIL tmo_singular: got %b want 1", singular); end
        checks++; if (det !== 32'h0) begin fails++; $display("FAIL tmo_det: got %h want 0", det); end
        release_out();
        add_en = 1'b1;
    endtask

    task automatic test_reset_mid_op;
        int n, m0;
        mlat = 5;
        m0 = n_mul;
        send(32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4080_0000);
        n = 0;
        while (n_mul - m0 < 2 && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (n_mul - m0 !== 2) begin fails++; $display("FAIL rmid_reach_bc: got %0d want 2", n_mul - m0); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); inj_mdone = 1'b1;
        @(negedge clk); inj_mdone = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++; if ({in_ready, out_valid, mul_start} !== 3'b100) begin fails++; $display("FAIL rmid_idle[%0d]: got %b want 100", i, {in_ready, out_valid, mul_start}); end
        end
        mlat = 1;
        send(32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 32'h4080_0000);
        wait_out(n);
        checks++; if (n !== 6) begin fails++; $display("FAIL rmid_next_latency: got %0d want 6", n); end
        checks++; if (det !== 32'h40A0_0000) begin fails++; $display("FAIL rmid_next_det: got %h want 40a00000", det); end
        checks++; if (error !== 1'b0) begin fails++; $display("FAIL rmid_next_error: got %b want 0", error); end
        release_out();
    endtask

    task automatic test_back_to_back;
        int ra, ac, t;
        ra = res_q.size(); ac = acc_q.size();
        @(negedge clk);
        a = 32'h4040_0000; b = 32'h4000_0000; c = 32'h3F80_0000; d = 32'h4080_0000;
        in_valid = 1'b1; out_ready = 1'b1;
        t = 0;
        while (acc_q.size() < ac + 1 && t < 100) begin @(negedge clk); t++; end
        a = 32'h4000_0000; b = 32'h3F80_0000; c = 32'h4040_0000; d = 32'h4080_0000;
        t = 0;
        while (acc_q.size() < ac + 2 && t < 100) begin @(negedge clk); t++; end
        in_valid = 1'b0;
        t = 0;
        while (res_q.size() < ra + 2 && t < 100) begin @(negedge clk); t++; end
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (res_q.size() !== ra + 2) begin fails++; $display("FAIL b2b_result_count: got %0d want %0d", res_q.size() - ra, 2); end
        checks++; if (acc_q.size() !== ac + 2) begin fails++; $display("FAIL b2b_accept_count: got %0d want 2", acc_q.size() - ac); end
        if (res_q.size() >= ra + 2 && acc_q.size() >= ac + 2) begin
            checks++; if (res_q[ra] !== 32'h4120_0000) begin fails++; $display("FAIL b2b_det0: got %h want 41200000", res_q[ra]); end
            checks++; if (res_q[ra+1] !== 32'h40A0_0000) begin fails++; $display("FAIL b2b_det1: got %h want 40a00000", res_q[ra+1]); end
            checks++; if (acc_q[ac+1] - acc_q[ac] !== 8) begin fails++; $display("FAIL b2b_accept_gap: got %0d want 8", acc_q[ac+1] - acc_q[ac]); end
            checks++; if (acc_a[ac+1] !== 32'h4000_0000) begin fails++; $display("FAIL b2b_second_a: got %h want 40000000", acc_a[ac+1]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_singular();
        test_slow_units();
        test_timeout();
        test_reset_mid_op();
        test_back_to_back();
        checks++; if (viol !== 0) begin fails++; $display("FAIL start_protocol: got %0d violations want 0", viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/det2_ctrl.md
DET2_CTRL -- requirements
Module: det2_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: IEEE-754 single-precision operand/result width.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles allowed for one arithmetic-unit operation.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  a,b,c,d hold a valid 2x2 matrix [a b; c d].
REQ-006 in_ready  output  1  controller can accept a matrix.
REQ-007 a, b, c, d  input  WIDTH each  matrix elements.
REQ-008 mul_start  output  1  one-cycle request to the shared multiplier.
REQ-009 mul_x, mul_y  output  WIDTH each  multiplier operands.
REQ-010 mul_done  input  1  one-cycle pulse; mul_result is valid.
REQ-011 mul_result  input  WIDTH  product.
REQ-012 add_start  output  1  one-cycle request to the shared adder.
REQ-013 add_x, add_y  output  WIDTH each  adder operands.
REQ-014 add_sub  output  1  1 = subtract (add_x - add_y).
REQ-015 add_done  input  1  one-cycle pulse; add_result is valid.
REQ-016 add_result  input  WIDTH  sum/difference.
REQ-017 out_valid  output  1  det, singular and error are valid.
REQ-018 out_ready  input  1  consumer accepts the result.
REQ-019 det  output  WIDTH  a*d - b*c.
REQ-020 singular  output  1  det is +0 or -0, i.e. det[30:0]==0.
REQ-021 error  output  1  a unit operation exceeded TIMEOUT cycles.

Function
REQ-022 FSM states: IDLE, MUL_AD, MUL_BC, SUB, DONE.
REQ-023 IDLE: in_ready=1; when in_valid=1, latch a,b,c,d into internal registers and go to MUL_AD.
REQ-024 In MUL_AD, mul_start SHALL pulse on the first cycle in the state, with mul_x=a and mul_y=d held until mul_done; on mul_done, latch ad and go to MUL_BC.
REQ-025 In MUL_BC, mul_start SHALL pulse on entry, with mul_x=b and mul_y=c; on mul_done, latch bc and go to SUB.
REQ-026 In SUB, add_start SHALL pulse on entry, with add_x=ad, add_y=bc and add_sub=1; on add_done, register det=add_result, compute singular from it, and go to DONE.
REQ-027 DONE: out_valid=1, with det, singular and error stable; when out_ready=1, go to IDLE. in_ready=0 in every state other than IDLE.
REQ-028 Latency from input accept to out_valid: 2 cycles of start overhead plus the mul latency twice plus the add latency plus 1 cycle; with a 1-cycle done response that is 6 cycles.
REQ-029 mul_start and add_start SHALL never both be high, and SHALL never re-pulse before the matching done.
REQ-030 mul_done/add_done arriving in any state other than the one waiting for it SHALL be ignored.
REQ-031 A per-operation cycle counter restarts on each start pulse. If it reaches TIMEOUT without done: set error=1 and det=0, force singular=1, and go to DONE.
REQ-032 Input changes outside the IDLE accept cycle SHALL have no effect.
REQ-033 Back-to-back operation: acceptance in the cycle after DONE handoff is permitted, with no bubble beyond the IDLE cycle.

Reset
REQ-034 While rst=1 at a clock edge: state=IDLE, in_ready=1 after release, and out_valid, mul_start, add_start, add_sub, error and singular all 0. det, mul_x/y and add_x/y SHALL be 0.
REQ-035 Reset mid-operation SHALL abandon the computation; a late done pulse after reset SHALL be ignored.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, WIDTH default, FP constant ZERO=32'h0, and the sign/magnitude field bounds.
REQ-037 One sub-module, op_timer (load on start, count, assert expired at TIMEOUT), is natural; everything else stays in det2_ctrl.

Verification
REQ-038 Use behavioural mul/adder models with 1-cycle done, a=0x40400000 (3.0), b=0x40000000 (2.0), c=0x3F800000 (1.0), d=0x40800000 (4.0) -> det=0x41200000 (10.0), singular=0, error=0, out_valid 6 cycles after accept.
REQ-039 a=0x40000000, b=0x40800000, c=0x3F800000, d=0x40000000 (2,4,1,2) -> det=0x00000000, singular=1.
REQ-040 Model latency of 5 cycles, with out_ready held 0 for 4 cycles in DONE -> det held stable, in_ready=0, and exactly two mul_start pulses and one add_start pulse.
REQ-041 add_done never asserted, TIMEOUT=8 -> error=1, singular=1, det=0 exactly 8 cycles after add_start.
REQ-042 rst asserted during MUL_BC, then a spurious mul_done after release -> state IDLE, no out_valid, and the next matrix computes correctly.
REQ-043 Two matrices streamed with in_valid held high and out_ready=1 -> two results in order, with the second matrix accepted only in IDLE.
